display_arbiter: RTL
====================

Name: display_arbiter

Overview:
- Owns the 8-digit seven-segment display.
- Generates the scan-rate tick from the system clock and sequences the digit scan: seg_sel, active-low anodes, current nibble.
- Arbitrates between two requesters that each want to show a 32-bit hex word.
- Grants change only at frame boundaries and are held for a minimum dwell, so the display never shows a torn or flickering word.

Parameters:
- TICK_DIV, 208334: system clocks per digit step (100 MHz / 480 Hz); legal range 1..2^20.
- DWELL_FRAMES, 8: minimum full scan frames a grant is held while the other requester waits; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants the display; higher priority from idle.
- data0  in  32  requester 0 word; nibble i is shown on digit i.
- req1  in  1  requester 1 wants the display.
- data1  in  32  requester 1 word.
- lz_blank  in  1  enable leading-zero suppression.
- gnt0  out  1  requester 0 owns the display.
- gnt1  out  1  requester 1 owns the display.
- anode  out  8  active-low digit enables; bit i drives a_i.
- seg_sel  out  3  index of the digit currently scanned.
- hex_out  out  4  nibble for the current digit.
- blank  out  1  current digit dark; downstream decoder drives segments off.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: tick counter 0, seg_sel 0, anode 8'hFF, hex_out 0, blank 1, frame_done 0, gnt0 0, gnt1 0, state IDLE, dwell 0, shadow word 0, started 0. Reset asserted mid-operation forces all of these on the next edge.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one cycle when count == TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- Scan:
  - On the first tick after reset, set started=1 and keep seg_sel at 0.
  - On each later tick, seg_sel increments modulo 8.
  - frame_done pulses in the cycle seg_sel is registered back to 0 from 7; it does not pulse on the first tick.
  - anode, hex_out and blank update in the same cycle as seg_sel. There is no extra latency.
- Digit outputs:
  - hex_out = shadow[4*seg_sel+3 : 4*seg_sel].
  - Digit i is blanked when state==IDLE, or when started==0, or when lz_blank=1 and i!=0 and shadow[31:4*i]==0.
  - Blanked: anode bit i = 1 and blank = 1. Otherwise anode = ~(8'b1<<seg_sel) and blank = 0.
  - Digit 0 is never leading-zero blanked.
- Arbiter FSM, states IDLE, GNT0, GNT1. gnt0 = (state==GNT0), gnt1 = (state==GNT1). All transitions are evaluated only on frame_done cycles.
  - IDLE: if req0, go to GNT0; else if req1, go to GNT1; else stay. Both requesting gives GNT0.
  - GNTx, holder dropped its request: go to the other grant if the other requests, else IDLE. This ignores dwell.
  - GNTx, holder still requesting, dwell==DWELL_FRAMES, other requesting: go to the other grant (round-robin).
  - GNTx, any other case: stay.
- Dwell counter:
  - Cleared on every state change.
  - Otherwise increments on each frame_done, saturating at DWELL_FRAMES.
- Shadow word:
  - On each frame_done, load data of the next-state owner: data0 for GNT0, data1 for GNT1, 0 for IDLE.
  - Held constant for the whole frame, so a mid-frame change on data0/data1 is not visible until the next frame.
- Request drop mid-frame: the grant stays asserted until frame_done.

Decomposition:
- Package disp_pkg:
  - Arbiter state enum {IDLE, GNT0, GNT1}.
  - NUM_DIGITS=8.
  - ANODE_OFF=8'hFF.
  - Nibble-select helper function.
- Sub-module scan_tick_gen (parameter TICK_DIV; ports clk, reset, tick) holds the divider.
- Scan, blanking and arbiter logic stay in display_arbiter.

Test Plan (TICK_DIV=4, DWELL_FRAMES=2):
1. Reset, no requests → anode=FF, blank=1 on every digit; frame_done pulses every 32 clk; gnt0=gnt1=0.
2. req0=1, data0=32'h1234_ABCD → gnt0 rises at the first frame_done; over the next frame hex_out reads D,C,B,A,4,3,2,1 on seg_sel 0..7; anode steps FE,FD,…,7F.
3. gnt0 held, req1=1 → gnt0 stays through 2 frame_done pulses, then gnt1=1 at the following frame_done. With req0 still high, the grant returns to gnt0 after 2 more frames.
4. req0 and req1 rise in the same cycle from IDLE → gnt0 granted; when req0 drops mid-frame, gnt1 is granted at the next frame_done with dwell ignored.
5. lz_blank=1, data0=32'h0000_00A5 → digits 0 and 1 lit showing 5 and A; digits 2..7 have anode bit 1 and blank=1. With data0=0, only digit 0 is lit, showing 0.
6. data0 changes mid-frame → hex_out holds the old word until frame_done. Reset asserted mid-frame → all reset values on the next edge and gnt0=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the 8-digit seven-segment display arbiter.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;

    // Nibble shown on digit idx: word[4*idx+3 : 4*idx].
    function automatic logic [3:0] nibble_sel(input logic [31:0] word, input logic [2:0] idx);
        nibble_sel = word[{idx, 2'b00} +: 4];
    endfunction

    // True when every nibble from digit idx upward is zero (leading-zero test).
    function automatic logic upper_zero(input logic [31:0] word, input logic [2:0] idx);
        logic [31:0] mask;
        mask       = 32'hFFFF_FFFF << {idx, 2'b00};
        upper_zero = ((word & mask) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/display_arbiter_tick.sv
// Scan-rate divider: tick is high for one clock every TICK_DIV clocks.
module scan_tick_gen #(
    parameter int TICK_DIV = 208334
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_s;

    // Wrap the divider on its terminal count.
    always_comb begin
        tick_s = (count_q == LAST);
        if (tick_s) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/display_arbiter.sv
// Seven-segment scan sequencer plus a frame-aligned, dwell-limited two-way
// arbiter deciding whose 32-bit word is shown.
module display_arbiter
    import disp_pkg::*;
#(
    parameter int TICK_DIV     = 208334,
    parameter int DWELL_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [31:0] data1,
    input  logic        lz_blank,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  anode,
    output logic [2:0]  seg_sel,
    output logic [3:0]  hex_out,
    output logic        blank,
    output logic        frame_done
);

    localparam logic [7:0] DWELL_MAX = 8'(DWELL_FRAMES);

    logic        tick_s;
    logic        wrap_s;
    logic        dark_s;

    arb_state_e  state_q,   state_d;
    logic [7:0]  dwell_q,   dwell_d;
    logic [31:0] shadow_q,  shadow_d;
    logic        started_q, started_d;
    logic [2:0]  seg_sel_q, seg_sel_d;
    logic [7:0]  anode_q,   anode_d;
    logic [3:0]  hex_q,     hex_d;
    logic        blank_q,   blank_d;
    logic        fd_q,      fd_d;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Digit sequencing; the first tick only arms the scan so no frame is cut short.
    always_comb begin
        started_d = started_q;
        seg_sel_d = seg_sel_q;
        wrap_s    = 1'b0;
        if (tick_s) begin
            if (!started_q) begin
                started_d = 1'b1;
                seg_sel_d = 3'd0;
            end else begin
                seg_sel_d = seg_sel_q + 3'd1;
                wrap_s    = (seg_sel_q == 3'd7);
            end
        end else begin
            seg_sel_d = seg_sel_q;
        end
    end

    // Arbiter next state, evaluated only as the scan wraps to digit 0.
    always_comb begin
        state_d = state_q;
        if (wrap_s) begin
            case (state_q)
                IDLE: begin
                    if (req0) begin
                        state_d = GNT0;
                    end else if (req1) begin
                        state_d = GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GNT0: begin
                    if (!req0) begin
                        state_d = req1 ? GNT1 : IDLE;
                    end else if (req1 && (dwell_q == DWELL_MAX)) begin
                        state_d = GNT1;
                    end else begin
                        state_d = GNT0;
                    end
                end
                GNT1: begin
                    if (!req1) begin
                        state_d = req0 ? GNT0 : IDLE;
                    end else if (req0 && (dwell_q == DWELL_MAX)) begin
                        state_d = GNT0;
                    end else begin
                        state_d = GNT1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Dwell count and the per-frame shadow copy of the owner's word.
    always_comb begin
        dwell_d  = dwell_q;
        shadow_d = shadow_q;
        if (wrap_s) begin
            if (state_d != state_q) begin
                dwell_d = 8'd0;
            end else if (dwell_q < DWELL_MAX) begin
                dwell_d = dwell_q + 8'd1;
            end else begin
                dwell_d = dwell_q;
            end
            case (state_d)
                GNT0:    shadow_d = data0;
                GNT1:    shadow_d = data1;
                default: shadow_d = 32'h0000_0000;
            endcase
        end else begin
            dwell_d  = dwell_q;
            shadow_d = shadow_q;
        end
    end

    // Digit drive uses next-state values so anode/hex line up with seg_sel.
    always_comb begin
        anode_d = anode_q;
        hex_d   = hex_q;
        blank_d = blank_q;
        fd_d    = wrap_s;
        dark_s  = (state_d == IDLE) || !started_d ||
                  (lz_blank && (seg_sel_d != 3'd0) && upper_zero(shadow_d, seg_sel_d));
        if (tick_s) begin
            hex_d = nibble_sel(shadow_d, seg_sel_d);
            if (dark_s) begin
                anode_d = ANODE_OFF;
                blank_d = 1'b1;
            end else begin
                anode_d = ~(8'b0000_0001 << seg_sel_d);
                blank_d = 1'b0;
            end
        end else begin
            hex_d = hex_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dwell_q   <= 8'd0;
            shadow_q  <= 32'h0000_0000;
            started_q <= 1'b0;
            seg_sel_q <= 3'd0;
            anode_q   <= ANODE_OFF;
            hex_q     <= 4'h0;
            blank_q   <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            shadow_q  <= shadow_d;
            started_q <= started_d;
            seg_sel_q <= seg_sel_d;
            anode_q   <= anode_d;
            hex_q     <= hex_d;
            blank_q   <= blank_d;
            fd_q      <= fd_d;
        end
    end

    assign gnt0       = (state_q == GNT0);
    assign gnt1       = (state_q == GNT1);
    assign anode      = anode_q;
    assign seg_sel    = seg_sel_q;
    assign hex_out    = hex_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;

endmodule
